clock_time_keeper: RTL
======================

# clock_time_keeper

Parametrised successor to the one-second tick generator and its seconds counter. It divides `clk` by a runtime divisor into a one-cycle tick and keeps a validated hours/minutes/seconds time-of-day. It adds:
- synchronous time load with range checking,
- 12/24-hour presentation,
- a one-shot alarm compare,
- a day-rollover strobe.

It sits between the board clock and the display/alarm logic of the clock design.

## Interface
Parameters:
- P_COUNT_BIT, 30, width of tick divider counter and i_freq
- P_SEC_BIT, 6, seconds field width (≥6)
- P_MIN_BIT, 6, minutes field width (≥6)
- P_HOUR_BIT, 5, hours field width (≥5)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_run_en  in  1  divider advances while high; holds (not clears) while low
- i_freq  in  P_COUNT_BIT  clk cycles per tick; 0 = no ticks
- i_mode_12h  in  1  1 = 12-hour presentation on o_hour/o_pm, 0 = 24-hour
- i_load  in  1  one-cycle strobe: load i_load_sec/min/hour
- i_load_sec / i_load_min / i_load_hour  in  P_SEC_BIT / P_MIN_BIT / P_HOUR_BIT  load value, always 24-hour
- o_load_err  out  1  one-cycle pulse: load rejected (out of range)
- i_alarm_en  in  1  alarm compare enable
- i_alarm_sec / i_alarm_min / i_alarm_hour  in  field widths  alarm time, 24-hour
- o_tick  out  1  one-cycle tick pulse
- o_sec / o_min  out  P_SEC_BIT / P_MIN_BIT  current time fields
- o_hour  out  P_HOUR_BIT  0..23 in 24h mode, 1..12 in 12h mode
- o_pm  out  1  internal hour ≥ 12 (valid in both modes)
- o_day_tick  out  1  one-cycle pulse on 23:59:59 → 00:00:00
- o_alarm  out  1  one-cycle alarm pulse

## Operation
- Reset (async assert, sync-safe deassert) forces: divider 0, time 00:00:00, o_tick/o_load_err/o_day_tick/o_alarm 0. o_hour reads 0 in 24h mode and 12 in 12h mode; o_pm is 0.
- Divider behaviour:
  - while i_run_en=1 and i_freq≠0: counts 0..i_freq−1.
  - terminal condition: counter ≥ i_freq−1. Using ≥ handles i_freq lowered mid-count: the next cycle wraps to 0.
  - i_freq=1: tick every cycle.
  - i_freq=0: counter held at 0, no ticks.
  - i_run_en=0: counter holds its value and o_tick=0.
- Time counting on each tick:
  - sec+1; at 59 it wraps to 0 and carries into min.
  - min wraps at 59 and carries into hour.
  - hour wraps at 23 → 0, and o_day_tick pulses.
  - Internal hour is always 0..23.
- Presentation:
  - 12h o_hour = (h mod 12 = 0) ? 12 : h mod 12.
  - Presentation is combinational from the internal registers; a mode change takes effect immediately and never alters stored time.
- Load:
  - Valid load (sec ≤ 59, min ≤ 59, hour ≤ 23): writes time, clears divider to 0, suppresses any tick in that cycle.
  - Invalid load: time and divider unchanged; o_load_err pulses.
  - Load has priority over a coincident tick; the tick is dropped, not deferred.
  - Load is accepted regardless of i_run_en.
- Alarm:
  - o_alarm pulses the cycle after a tick-driven update makes the time equal the alarm fields while i_alarm_en=1.
  - Loads never trigger the alarm, even onto a matching time.
  - Alarm values out of range never match.

## Timing
- Tick latency: with the divider at i_freq−1 on edge N, the edge N+1 sets o_tick=1 and updates the time fields together. Time changes in the same cycle o_tick is high.
- Tick period is exactly i_freq cycles while running with constant i_freq.
- o_day_tick is coincident with o_tick on the rollover update.
- o_alarm is one cycle after o_tick.
- o_load_err is registered and asserts one cycle after the i_load strobe.
- A valid load updates the fields one edge after the i_load strobe; the next tick follows i_freq cycles later.
- Reset mid-count or mid-pulse clears all state immediately; no pending pulse survives.

## Structure
- Package clock_pkg: constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, HOUR_12=12; function to_12h(hour).
- Sub-module clock_tick_div: divider with i_run_en, i_freq, a sync clear (driven by valid load) and o_tick.
- The top level holds the time registers, load check, presentation, rollover and alarm logic.

## Test plan
- Divider: i_freq=4, run → o_tick every 4th cycle. Drop i_run_en for 3 cycles mid-count → period stretched by exactly 3. i_freq=0 → no ticks. i_freq=1 → tick every cycle.
- Carry chain: load 23:59:58, i_freq=2 → 23:59:59, then 00:00:00 with o_day_tick=1 coincident with o_tick.
- Load check: load 12:60:00 → o_load_err pulse, time unchanged. Load 13:45:30 coincident with terminal count → time 13:45:30, no tick, next tick 4 cycles later (i_freq=4).
- 12h mode: internal 00:xx → o_hour=12, o_pm=0. 13:00 → o_hour=1, o_pm=1. Toggle the mode → stored time unchanged.
- Alarm: alarm 00:00:05, tick from 00:00:04 → o_alarm one cycle after o_tick. Load 00:00:05 directly → no alarm. i_alarm_en=0 → no alarm.
- Async reset asserted between clock edges mid-count → all outputs at reset values before the next edge. Counting restarts from 00:00:00 after release.

Source files
------------

// File: rtl/clock_pkg.sv
// ============================================================
// Module  : clock_pkg
// Purpose : time-of-day limits and 12-hour conversion helper
// Revision: 1.0
// ============================================================
`default_nettype none

package clock_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int HOUR_12  = 12;

  // Midnight and noon both present as 12
  function automatic logic [4:0] to_12h(input logic [4:0] hour);
    logic [4:0] h;
    h = (hour >= 5'(HOUR_12)) ? hour - 5'(HOUR_12) : hour;
    return (h == 5'd0) ? 5'(HOUR_12) : h;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_tick_div.sv
// ============================================================
// Module  : clock_tick_div
// Purpose : runtime divisor producing a one-cycle tick
// Revision: 1.0
// ============================================================
`default_nettype none

module clock_tick_div #(
  parameter int P_COUNT_BIT = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_clear,
  output logic                   o_fire,
  output logic                   o_tick
);

  logic [P_COUNT_BIT-1:0] r_count;
  logic                   r_tick;
  logic                   w_active;
  logic                   w_fire;

  assign w_active = i_run_en && (i_freq != '0);
  // >= so a divisor lowered below the current count wraps on the next edge
  assign w_fire   = w_active && (r_count >= i_freq - P_COUNT_BIT'(1));
  assign o_fire   = w_fire;
  assign o_tick   = r_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_fire && !i_clear;
      if (i_clear || (i_freq == '0)) begin
        r_count <= '0;
      end else if (w_fire) begin
        r_count <= '0;
      end else if (i_run_en) begin
        r_count <= r_count + P_COUNT_BIT'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_time_keeper.sv
// ============================================================
// Module  : clock_time_keeper
// Purpose : h:m:s time-of-day with load check, 12/24h view, alarm
// Revision: 1.0
// ============================================================
`default_nettype none

module clock_time_keeper
  import clock_pkg::*;
#(
  parameter int P_COUNT_BIT = 30,
  parameter int P_SEC_BIT   = 6,
  parameter int P_MIN_BIT   = 6,
  parameter int P_HOUR_BIT  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_mode_12h,
  input  logic                   i_load,
  input  logic [P_SEC_BIT-1:0]   i_load_sec,
  input  logic [P_MIN_BIT-1:0]   i_load_min,
  input  logic [P_HOUR_BIT-1:0]  i_load_hour,
  output logic                   o_load_err,
  input  logic                   i_alarm_en,
  input  logic [P_SEC_BIT-1:0]   i_alarm_sec,
  input  logic [P_MIN_BIT-1:0]   i_alarm_min,
  input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
  output logic                   o_tick,
  output logic [P_SEC_BIT-1:0]   o_sec,
  output logic [P_MIN_BIT-1:0]   o_min,
  output logic [P_HOUR_BIT-1:0]  o_hour,
  output logic                   o_pm,
  output logic                   o_day_tick,
  output logic                   o_alarm
);

  localparam logic [P_SEC_BIT-1:0]  C_SEC_MAX  = P_SEC_BIT'(SEC_MAX);
  localparam logic [P_MIN_BIT-1:0]  C_MIN_MAX  = P_MIN_BIT'(MIN_MAX);
  localparam logic [P_HOUR_BIT-1:0] C_HOUR_MAX = P_HOUR_BIT'(HOUR_MAX);
  localparam logic [P_HOUR_BIT-1:0] C_HOUR_12  = P_HOUR_BIT'(HOUR_12);

  logic [P_SEC_BIT-1:0]  r_sec;
  logic [P_MIN_BIT-1:0]  r_min;
  logic [P_HOUR_BIT-1:0] r_hour;
  logic                  r_load_err;
  logic                  r_day_tick;
  logic                  r_alarm;

  logic w_load_ok;
  logic w_load_valid;
  logic w_fire;
  logic w_tick;
  logic w_advance;
  logic w_alarm_match;

  assign w_load_ok    = (i_load_sec <= C_SEC_MAX) && (i_load_min <= C_MIN_MAX) &&
                        (i_load_hour <= C_HOUR_MAX);
  assign w_load_valid = i_load && w_load_ok;
  // A valid load wins over a coincident terminal count; that tick is lost
  assign w_advance    = w_fire && !w_load_valid;

  clock_tick_div #(
    .P_COUNT_BIT(P_COUNT_BIT)
  ) u_tick_div (
    .clk      (clk),
    .reset    (reset),
    .i_run_en (i_run_en),
    .i_freq   (i_freq),
    .i_clear  (w_load_valid),
    .o_fire   (w_fire),
    .o_tick   (w_tick)
  );

  // Stored time is always in range, so out-of-range alarm fields never match
  assign w_alarm_match = (r_sec == i_alarm_sec) && (r_min == i_alarm_min) &&
                         (r_hour == i_alarm_hour);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec      <= '0;
      r_min      <= '0;
      r_hour     <= '0;
      r_load_err <= 1'b0;
      r_day_tick <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_load_err <= i_load && !w_load_ok;
      r_day_tick <= 1'b0;
      r_alarm    <= w_tick && i_alarm_en && w_alarm_match;
      if (w_load_valid) begin
        r_sec  <= i_load_sec;
        r_min  <= i_load_min;
        r_hour <= i_load_hour;
      end else if (w_advance) begin
        if (r_sec == C_SEC_MAX) begin
          r_sec <= '0;
          if (r_min == C_MIN_MAX) begin
            r_min <= '0;
            if (r_hour == C_HOUR_MAX) begin
              r_hour     <= '0;
              r_day_tick <= 1'b1;
            end else begin
              r_hour <= r_hour + P_HOUR_BIT'(1);
            end
          end else begin
            r_min <= r_min + P_MIN_BIT'(1);
          end
        end else begin
          r_sec <= r_sec + P_SEC_BIT'(1);
        end
      end
    end
  end

  assign o_tick     = w_tick;
  assign o_sec      = r_sec;
  assign o_min      = r_min;
  assign o_hour     = i_mode_12h ? P_HOUR_BIT'(to_12h(r_hour[4:0])) : r_hour;
  assign o_pm       = (r_hour >= C_HOUR_12);
  assign o_load_err = r_load_err;
  assign o_day_tick = r_day_tick;
  assign o_alarm    = r_alarm;

endmodule

`default_nettype wire
